// File: rtl/fifo_write_control.sv
// Write-side controller of the async FIFO: write pointer, memory address and
// full / almost-full / fill-level flags derived from the synchronised gray read pointer.
module fifo_write_control #(
    parameter int address_width   = 4,
    parameter int almost_full_thr = 12
) (
    input  logic                     w_clk,
    input  logic                     w_rst,
    input  logic                     w_inc,
    input  logic [address_width:0]   r_ptr_sync,
    input  logic                     ovf_clr,
    output logic                     w_en,
    output logic [address_width-1:0] w_addre,
    output logic [address_width:0]   w_ptr,
    output logic                     is_full,
    output logic                     almost_full,
    output logic [address_width:0]   w_level,
    output logic                     overflow
);

    localparam int AW = address_width;
    localparam logic [AW:0] AF_THR = (AW + 1)'(almost_full_thr);

    logic          accept;
    logic          ovf_event;
    logic [AW:0]   w_bin;
    logic [AW:0]   w_bin_next;
    logic [AW:0]   w_gray_next;
    logic [AW:0]   r_bin;
    logic [AW:0]   full_pattern;
    logic [AW:0]   level_next;

    // Write enable is deliberately not reset-gated; pointers stay at 0 while in reset anyway.
    assign w_en      = w_inc & ~is_full;
    assign accept    = w_en;
    assign ovf_event = w_inc & is_full;

    assign w_bin_next  = w_bin + {{AW{1'b0}}, accept};
    assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;

    // Gray-to-binary: bit i is the XOR of all gray bits from i up to the MSB.
    always_comb begin
        r_bin = '0;
        for (int i = 0; i <= AW; i++) begin
            r_bin[i] = ^(r_ptr_sync >> i);
        end
    end

    // Full when the write pointer is one whole lap ahead: top two gray bits inverted.
    assign full_pattern = {~r_ptr_sync[AW:AW-1], r_ptr_sync[AW-2:0]};
    assign level_next   = w_bin_next - r_bin;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and ordering between blocks cannot matter.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            w_bin       <= '0;
            w_addre     <= '0;
            w_ptr       <= '0;
            is_full     <= 1'b0;
            almost_full <= 1'b0;
            w_level     <= '0;
            overflow    <= 1'b0;
        end else begin
            w_bin       <= w_bin_next;
            w_addre     <= w_bin_next[AW-1:0];
            w_ptr       <= w_gray_next;
            is_full     <= (w_gray_next == full_pattern);
            almost_full <= (level_next >= AF_THR);
            w_level     <= level_next;
            // A fresh overflow wins over a simultaneous clear.
            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_control.sv
// Directed self-checking bench for fifo_write_control (address_width=4, almost_full_thr=12).
module tb_fifo_write_control;

    logic       w_clk = 1'b0;
    logic       w_rst;
    logic       w_inc;
    logic [4:0] r_ptr_sync;
    logic       ovf_clr;
    logic       w_en;
    logic [3:0] w_addre;
    logic [4:0] w_ptr;
    logic       is_full;
    logic       almost_full;
    logic [4:0] w_level;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    int exp_w    = 0;
    int exp_r    = 0;

    fifo_write_control #(.address_width(4), .almost_full_thr(12)) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .w_inc       (w_inc),
        .r_ptr_sync  (r_ptr_sync),
        .ovf_clr     (ovf_clr),
        .w_en        (w_en),
        .w_addre     (w_addre),
        .w_ptr       (w_ptr),
        .is_full     (is_full),
        .almost_full (almost_full),
        .w_level     (w_level),
        .overflow    (overflow)
    );

    always #5 w_clk = ~w_clk;

    function automatic logic [4:0] gray(input int b);
        logic [4:0] x;
        x = 5'(b % 32);
        return x ^ (x >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    initial begin
        // 1: reset with a pending write request
        w_rst = 1'b0; w_inc = 1'b1; r_ptr_sync = 5'b0; ovf_clr = 1'b0;
        step(); step();
        check("rst_w_ptr", 32'(w_ptr), 32'h0);
        check("rst_w_addre", 32'(w_addre), 32'h0);
        check("rst_is_full", 32'(is_full), 32'h0);
        check("rst_w_level", 32'(w_level), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_almost_full", 32'(almost_full), 32'h0);
        check("rst_w_en", 32'(w_en), 32'h1);

        // 2: fill with read pointer at 0
        w_rst = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            exp_w = i;
            check("fill_w_level", 32'(w_level), 32'(i));
            check("fill_w_addre", 32'(w_addre), 32'(i % 16));
            check("fill_w_ptr", 32'(w_ptr), 32'(gray(i)));
            check("fill_almost_full", 32'(almost_full), 32'(i >= 12));
            check("fill_is_full", 32'(is_full), 32'(i == 16));
        end
        check("full_w_ptr_11000", 32'(w_ptr), 32'b11000);
        check("full_w_en", 32'(w_en), 32'h0);
        step();
        check("ovf_w_ptr_held", 32'(w_ptr), 32'b11000);
        check("ovf_w_level", 32'(w_level), 32'd16);
        check("ovf_set", 32'(overflow), 32'h1);

        // 3: drain from full
        w_inc = 1'b0; r_ptr_sync = 5'b00110; exp_r = 4;
        step();
        check("drain4_is_full", 32'(is_full), 32'h0);
        check("drain4_w_level", 32'(w_level), 32'd12);
        check("drain4_almost_full", 32'(almost_full), 32'h1);
        r_ptr_sync = 5'b00111; exp_r = 5;
        step();
        check("drain5_w_level", 32'(w_level), 32'd11);
        check("drain5_almost_full", 32'(almost_full), 32'h0);
        check("drain5_overflow_sticky", 32'(overflow), 32'h1);

        // 4: writes track reads across the pointer wrap
        for (int j = 0; j < 18; j++) begin
            w_inc = 1'b1;
            exp_r = exp_r + 1;
            r_ptr_sync = gray(exp_r);
            step();
            exp_w = exp_w + 1;
            check("wrap_w_level", 32'(w_level), 32'd11);
            check("wrap_is_full", 32'(is_full), 32'h0);
            check("wrap_w_ptr", 32'(w_ptr), 32'(gray(exp_w)));
            check("wrap_w_addre", 32'(w_addre), 32'(exp_w % 16));
            if (exp_w == 31) check("wrap_gray_31", 32'(w_ptr), 32'b10000);
            if (exp_w == 32) begin
                check("wrap_gray_0", 32'(w_ptr), 32'b00000);
                check("wrap_addr_0", 32'(w_addre), 32'h0);
            end
        end

        // 5: overflow clear behaviour
        w_inc = 1'b0; ovf_clr = 1'b1;
        step();
        check("ovf_clear_idle", 32'(overflow), 32'h0);
        ovf_clr = 1'b0; w_inc = 1'b1;
        for (int k = 12; k <= 16; k++) begin
            step();
            exp_w = exp_w + 1;
            check("refill_w_level", 32'(w_level), 32'(k));
        end
        check("refill_is_full", 32'(is_full), 32'h1);
        check("refill_w_ptr", 32'(w_ptr), 32'(gray(exp_w)));
        ovf_clr = 1'b1;
        step();
        check("ovf_set_beats_clear", 32'(overflow), 32'h1);
        check("ovf_ptr_held", 32'(w_ptr), 32'(gray(exp_w)));
        w_inc = 1'b0;
        step();
        check("ovf_clear_after", 32'(overflow), 32'h0);
        ovf_clr = 1'b0;

        // 6: async reset mid-fill at level 7
        r_ptr_sync = 5'b00000;
        step();
        check("pre_async_w_level", 32'(w_level), 32'd7);
        w_inc = 1'b1;
        #2;
        w_rst = 1'b0;
        #1;
        check("async_w_ptr", 32'(w_ptr), 32'h0);
        check("async_w_addre", 32'(w_addre), 32'h0);
        check("async_is_full", 32'(is_full), 32'h0);
        check("async_almost_full", 32'(almost_full), 32'h0);
        check("async_w_level", 32'(w_level), 32'h0);
        check("async_overflow", 32'(overflow), 32'h0);
        w_inc = 1'b0;
        #1;
        w_rst = 1'b1;
        step();
        w_inc = 1'b1;
        step();
        check("post_rst_w_ptr", 32'(w_ptr), 32'b00001);
        check("post_rst_w_addre", 32'(w_addre), 32'h1);
        check("post_rst_w_level", 32'(w_level), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
